// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory bus between IF and MEM.
// Alternating priority on contention, registered ready pulses.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifc_ce,
  input  logic [ADDR_W-1:0]   ifc_addr,
  output logic [DATA_W-1:0]   ifc_data,
  output logic                ifc_ready,
  output logic                stallreq_from_if,
  input  logic                mem_ce,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_sel,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ready,
  output logic                stallreq_from_mem,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_sel,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int SEL_W = DATA_W / 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GNT_IF  = 2'd1;
  localparam logic [1:0] GNT_MEM = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              last_mem_q, last_mem_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0] ifc_data_q, ifc_data_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              ifc_ready_q, ifc_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic              pick_mem;

  // Next-state: arbitrate in IDLE, hold bus until ack, one DONE cycle.
  always_comb begin
    state_d     = state_q;
    last_mem_d  = last_mem_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    ifc_data_d  = ifc_data_q;
    mem_rdata_d = mem_rdata_q;
    ifc_ready_d = 1'b0;
    mem_ready_d = 1'b0;
    pick_mem    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ifc_ce || mem_ce) begin
          // On contention MEM wins unless it owned the last grant.
          pick_mem   = mem_ce && (!ifc_ce || !last_mem_q);
          bus_req_d  = 1'b1;
          last_mem_d = pick_mem;
          if (pick_mem) begin
            state_d     = GNT_MEM;
            bus_we_d    = mem_we;
            bus_addr_d  = mem_addr;
            bus_wdata_d = mem_wdata;
            bus_sel_d   = mem_sel;
          end else begin
            state_d     = GNT_IF;
            bus_we_d    = 1'b0;
            bus_addr_d  = ifc_addr;
            bus_wdata_d = '0;
            bus_sel_d   = '1;
          end
        end
      end
      GNT_IF: begin
        if (bus_ack) begin
          bus_req_d   = 1'b0;
          ifc_data_d  = bus_rdata;
          ifc_ready_d = ifc_ce;
          state_d     = DONE;
        end
      end
      GNT_MEM: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            mem_rdata_d = bus_rdata;
          end
          mem_ready_d = mem_ce;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_mem_q  <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      ifc_data_q  <= '0;
      mem_rdata_q <= '0;
      ifc_ready_q <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_mem_q  <= last_mem_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      ifc_data_q  <= ifc_data_d;
      mem_rdata_q <= mem_rdata_d;
      ifc_ready_q <= ifc_ready_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  assign ifc_data  = ifc_data_q;
  assign ifc_ready = ifc_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_ready_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_sel   = bus_sel_q;

  assign stallreq_from_if  = ifc_ce & ~ifc_ready_q;
  assign stallreq_from_mem = mem_ce & ~mem_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with memory responder model
// and a scoreboard of expected ready results.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifc_ce = 1'b0;
  logic [31:0] ifc_addr = '0;
  logic [31:0] ifc_data;
  logic        ifc_ready;
  logic        stallreq_from_if;
  logic        mem_ce = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_sel = 4'hF;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stallreq_from_mem;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  logic        r_ack = 1'b0;
  logic [31:0] r_rdata = '0;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = '0;

  assign bus_ack   = r_ack | m_ack;
  assign bus_rdata = m_ack ? m_rdata : r_rdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifc_ce(ifc_ce), .ifc_addr(ifc_addr), .ifc_data(ifc_data),
    .ifc_ready(ifc_ready), .stallreq_from_if(stallreq_from_if),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .stallreq_from_mem(stallreq_from_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
  } exp_t;
  exp_t        sbq[$];
  logic [31:0] glog[$];
  logic [31:0] mem_model[logic [31:0]];
  int          lat = 0;
  int          cnt = 0;
  logic [31:0] wtmp;
  logic        prev_req = 1'b0;
  exp_t        e;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic exp_t mk(bit m, logic [31:0] d);
    exp_t x;
    x.is_mem = m;
    x.data   = d;
    return x;
  endfunction

  // Memory responder: acks in the lat-th cycle of bus_req.
  initial begin
    forever begin
      @(posedge clk); #1;
      r_ack = 1'b0;
      if (bus_req && lat != 0) begin
        cnt++;
        if (cnt == lat) begin
          r_ack = 1'b1;
          cnt = 0;
          if (bus_we) begin
            wtmp = rd(bus_addr);
            for (int b = 0; b < 4; b++)
              if (bus_sel[b]) wtmp[8*b +: 8] = bus_wdata[8*b +: 8];
            mem_model[bus_addr] = wtmp;
            r_rdata = $urandom;
          end else begin
            r_rdata = rd(bus_addr);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor and grant-order log.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_req && !prev_req) glog.push_back(bus_addr);
      prev_req = bus_req;
      if (ifc_ready || mem_ready)
        chk("ready_excl", {63'd0, ifc_ready & mem_ready}, 64'd0);
      if (ifc_ready) begin
        chk("if_expected", {63'd0, sbq.size() > 0}, 64'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("if_owner", {63'd0, e.is_mem}, 64'd0);
          chk("if_data", {32'd0, ifc_data}, {32'd0, e.data});
        end
      end
      if (mem_ready) begin
        chk("mem_expected", {63'd0, sbq.size() > 0}, 64'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("mem_owner", {63'd0, e.is_mem}, 64'd1);
          chk("mem_data", {32'd0, mem_rdata}, {32'd0, e.data});
        end
      end
    end else begin
      prev_req = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic serve(int n, bit hold);
    int got = 0;
    int cyc = 0;
    bit fi, fm;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      fi = ifc_ready;
      fm = mem_ready;
      got += int'(fi) + int'(fm);
      cyc++;
      @(posedge clk); #1;
      if (!hold) begin
        if (fi) ifc_ce = 1'b0;
        if (fm) begin mem_ce = 1'b0; mem_we = 1'b0; end
      end
      if (got >= n) begin
        ifc_ce = 1'b0; mem_ce = 1'b0; mem_we = 1'b0;
      end
    end
    chk("serve_done", {63'd0, got >= n}, 64'd1);
  endtask

  initial begin
    mem_model[32'h100] = 32'h2401_0005;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_bus_req", {63'd0, bus_req}, 64'd0);
    chk("rst_ifc_ready", {63'd0, ifc_ready}, 64'd0);
    chk("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
    chk("rst_ifc_data", {32'd0, ifc_data}, 64'd0);
    chk("rst_mem_rdata", {32'd0, mem_rdata}, 64'd0);
    step(); step();
    rst = 1'b0;

    // IF read, ack latency 3
    lat = 3;
    step();
    ifc_ce = 1'b1; ifc_addr = 32'h100;
    sbq.push_back(mk(0, 32'h2401_0005));
    @(negedge clk);
    chk("c0_stall_if", {63'd0, stallreq_from_if}, 64'd1);
    chk("c0_bus_req", {63'd0, bus_req}, 64'd0);
    for (int c = 1; c <= 3; c++) begin
      step(); @(negedge clk);
      chk("gnt_bus_req", {63'd0, bus_req}, 64'd1);
      chk("gnt_bus_addr", {32'd0, bus_addr}, 64'h100);
      chk("gnt_bus_we", {63'd0, bus_we}, 64'd0);
      chk("gnt_bus_sel", {60'd0, bus_sel}, 64'hF);
      chk("gnt_stall_if", {63'd0, stallreq_from_if}, 64'd1);
      chk("gnt_ack", {63'd0, bus_ack}, {63'd0, c == 3});
    end
    step(); @(negedge clk);
    chk("c4_ifc_ready", {63'd0, ifc_ready}, 64'd1);
    chk("c4_ifc_data", {32'd0, ifc_data}, 64'h2401_0005);
    chk("c4_stall_if", {63'd0, stallreq_from_if}, 64'd0);
    chk("c4_bus_req", {63'd0, bus_req}, 64'd0);
    step();
    ifc_ce = 1'b0;

    // MEM read so mem_rdata holds data before reset
    lat = 2;
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_sel = 4'hF;
    sbq.push_back(mk(1, rd(32'h200)));
    serve(1, 0);

    // Asynchronous reset mid-transaction
    lat = 0;
    mem_ce = 1'b1; mem_addr = 32'h200;
    step(); @(negedge clk);
    chk("pre_rst_req", {63'd0, bus_req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_bus_req", {63'd0, bus_req}, 64'd0);
    chk("arst_ifc_data", {32'd0, ifc_data}, 64'd0);
    chk("arst_mem_rdata", {32'd0, mem_rdata}, 64'd0);
    chk("arst_ready", {62'd0, ifc_ready, mem_ready}, 64'd0);
    chk("arst_bus_addr", {32'd0, bus_addr}, 64'd0);
    mem_ce = 1'b0;
    step(); step();
    rst = 1'b0;

    // Simultaneous requests after reset: MEM first, then IF
    lat = 2;
    glog.delete();
    ifc_ce = 1'b1; ifc_addr = 32'h104;
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h200;
    sbq.push_back(mk(1, rd(32'h200)));
    sbq.push_back(mk(0, rd(32'h104)));
    serve(2, 0);
    chk("sim_gcount", glog.size(), 64'd2);
    if (glog.size() == 2) begin
      chk("sim_g0", {32'd0, glog[0]}, 64'h200);
      chk("sim_g1", {32'd0, glog[1]}, 64'h104);
    end

    // Both held: grants alternate MEM, IF, MEM
    glog.delete();
    ifc_ce = 1'b1; mem_ce = 1'b1;
    sbq.push_back(mk(1, rd(32'h200)));
    sbq.push_back(mk(0, rd(32'h104)));
    sbq.push_back(mk(1, rd(32'h200)));
    serve(3, 1);
    chk("alt_gcount", glog.size(), 64'd3);
    if (glog.size() == 3) begin
      chk("alt_g0", {32'd0, glog[0]}, 64'h200);
      chk("alt_g1", {32'd0, glog[1]}, 64'h104);
      chk("alt_g2", {32'd0, glog[2]}, 64'h200);
    end

    // Partial write: mem_rdata keeps prior load data
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 32'h300;
    mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'b0011;
    sbq.push_back(mk(1, rd(32'h200)));
    for (int c = 1; c <= 2; c++) begin
      step(); @(negedge clk);
      chk("wr_req", {63'd0, bus_req}, 64'd1);
      chk("wr_we", {63'd0, bus_we}, 64'd1);
      chk("wr_sel", {60'd0, bus_sel}, 64'h3);
      chk("wr_wdata", {32'd0, bus_wdata}, 64'hDEAD_BEEF);
      chk("wr_addr", {32'd0, bus_addr}, 64'h300);
      chk("wr_stall_mem", {63'd0, stallreq_from_mem}, 64'd1);
    end
    serve(1, 0);

    // Read back the merged word
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; mem_sel = 4'hF;
    sbq.push_back(mk(1, 32'hA5A5_BEEF));
    serve(1, 0);

    // Abandon: IF drops ce during GNT_IF
    lat = 3;
    ifc_ce = 1'b1; ifc_addr = 32'h108;
    step();
    step();
    ifc_ce = 1'b0;
    step(); @(negedge clk);
    chk("ab_ack", {63'd0, bus_ack}, 64'd1);
    step();
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h204;
    sbq.push_back(mk(1, rd(32'h204)));
    @(negedge clk);
    chk("ab_done_ready", {62'd0, ifc_ready, mem_ready}, 64'd0);
    chk("ab_done_req", {63'd0, bus_req}, 64'd0);
    step(); @(negedge clk);
    chk("ab_idle_req", {63'd0, bus_req}, 64'd0);
    chk("ab_idle_ready", {63'd0, ifc_ready}, 64'd0);
    step(); @(negedge clk);
    chk("ab_regrant_req", {63'd0, bus_req}, 64'd1);
    chk("ab_regrant_addr", {32'd0, bus_addr}, 64'h204);
    serve(1, 0);

    // Stray ack in IDLE
    lat = 2;
    ifc_ce = 1'b1; ifc_addr = 32'h110;
    sbq.push_back(mk(0, rd(32'h110)));
    serve(1, 0);
    m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
    step();
    m_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("st_ready", {62'd0, ifc_ready, mem_ready}, 64'd0);
      chk("st_req", {63'd0, bus_req}, 64'd0);
      chk("st_ifc_data", {32'd0, ifc_data}, {32'd0, rd(32'h110)});
      chk("st_mem_rdata", {32'd0, mem_rdata}, {32'd0, rd(32'h204)});
      step();
    end
    ifc_ce = 1'b1; ifc_addr = 32'h114;
    sbq.push_back(mk(0, rd(32'h114)));
    serve(1, 0);

    // Stray ack after reset drops mid-transaction
    lat = 0;
    ifc_ce = 1'b1; ifc_addr = 32'h118;
    step(); @(negedge clk);
    chk("rs_pre_req", {63'd0, bus_req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rs_req", {63'd0, bus_req}, 64'd0);
    ifc_ce = 1'b0;
    step();
    rst = 1'b0;
    m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
    step();
    m_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rs_ready", {62'd0, ifc_ready, mem_ready}, 64'd0);
      chk("rs_req_idle", {63'd0, bus_req}, 64'd0);
      chk("rs_ifc_data", {32'd0, ifc_data}, 64'd0);
      chk("rs_mem_rdata", {32'd0, mem_rdata}, 64'd0);
      step();
    end
    lat = 2;
    ifc_ce = 1'b1; ifc_addr = 32'h11C;
    sbq.push_back(mk(0, rd(32'h11C)));
    serve(1, 0);

    step(); step();
    chk("sb_empty", sbq.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
